// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute stage wrapped around the 8-bit ALU:
//   - ALU opcode constants, passed straight through to the ALU
//   - execute-stage FSM state encoding
// No ports; imported with "import alu_pkg::*;".
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SBC   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_NOT   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd11;
  localparam logic [3:0] OP_SHL   = 4'd12;
  localparam logic [3:0] OP_SHR   = 4'd13;

  // IDLE accepts, EXEC waits one cycle for the ALU, RESP holds the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } exec_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// ---------------------------------------------------------------------------
// alu_exec_if
// Bundles every non-clock signal of the execute stage:
//   - instruction handshake  : in_valid/in_ready + in_op/in_rd/in_ra/in_rb/
//                              in_use_imm/in_imm/in_wb
//   - ALU feed               : alu_a/alu_b/alu_carry/alu_op (stage -> ALU)
//   - ALU return             : alu_c/alu_carry_out/alu_zero (ALU -> stage)
//   - result handshake       : out_valid/out_ready + out_result/out_carry/
//                              out_zero
// Modports:
//   slave  : the execute stage itself
//   master : everything around it (upstream, ALU, downstream)
// Parameter RW is the register address width.
// ---------------------------------------------------------------------------
interface alu_exec_if #(
  parameter int RW = 3
);

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_ra;
  logic [RW-1:0] in_rb;
  logic          in_use_imm;
  logic [7:0]    in_imm;
  logic          in_wb;

  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic          alu_carry;
  logic [3:0]    alu_op;
  logic [7:0]    alu_c;
  logic          alu_carry_out;
  logic          alu_zero;

  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_result;
  logic          out_carry;
  logic          out_zero;

  modport slave (
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm, in_wb,
    output in_ready,
    output alu_a, alu_b, alu_carry, alu_op,
    input  alu_c, alu_carry_out, alu_zero,
    output out_valid, out_result, out_carry, out_zero,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm, in_wb,
    input  in_ready,
    input  alu_a, alu_b, alu_carry, alu_op,
    output alu_c, alu_carry_out, alu_zero,
    input  out_valid, out_result, out_carry, out_zero,
    output out_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// NREGS x 8-bit register file, cleared by reset. r0 is an ordinary register.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ra_i, rb_i          : read addresses (combinational read ports)
//   rdata_a_o, rdata_b_o: read data, reflects contents before the next edge
//   we_i, wa_i, wd_i    : synchronous write enable / address / data
// ---------------------------------------------------------------------------
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] ra_i,
  input  logic [RW-1:0] rb_i,
  output logic [7:0]    rdata_a_o,
  output logic [7:0]    rdata_b_o,
  input  logic          we_i,
  input  logic [RW-1:0] wa_i,
  input  logic [7:0]    wd_i
);

  logic [7:0] regs_q [NREGS];

  // Storage: whole array clears on reset, one write per cycle otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rdata_a_o = regs_q[ra_i];
  assign rdata_b_o = regs_q[rb_i];

endmodule

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
// Sequential execute stage around the external combinational 8-bit ALU.
// Accepts one instruction, latches its operands from the register file (or
// immediate), gives the ALU one full cycle, captures the ALU result/flags,
// optionally writes the result back, and presents it downstream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_exec_if slave modport (instruction handshake, ALU
//                feed/return, result handshake)
// Parameters:
//   NREGS : number of 8-bit registers (power of two)
//   RW    : register address width, must match the interface's RW
// ---------------------------------------------------------------------------
module alu_exec
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_exec_if.slave bus
);

  exec_state_e   state_q;
  exec_state_e   state_d;

  logic [7:0]    alu_a_q;
  logic [7:0]    alu_b_q;
  logic [3:0]    alu_op_q;
  logic [RW-1:0] rd_q;
  logic          wb_q;
  logic          carry_q;

  logic [7:0]    out_result_q;
  logic          out_carry_q;
  logic          out_zero_q;

  logic [7:0]    rdata_a;
  logic [7:0]    rdata_b;
  logic          accept;
  logic          capture;
  logic          reg_we;

  assign accept  = (state_q == ST_IDLE) && bus.in_valid;
  assign capture = (state_q == ST_EXEC);
  assign reg_we  = capture && wb_q;

  alu_regfile #(
    .NREGS(NREGS),
    .RW   (RW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_i     (bus.in_ra),
    .rb_i     (bus.in_rb),
    .rdata_a_o(rdata_a),
    .rdata_b_o(rdata_b),
    .we_i     (reg_we),
    .wa_i     (rd_q),
    .wd_i     (bus.alu_c)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: EXEC always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch on accept; these registers drive the ALU directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
    end else if (accept) begin
      alu_a_q  <= bus.in_use_imm ? bus.in_imm : rdata_a;
      alu_b_q  <= rdata_b;
      alu_op_q <= bus.in_op;
      rd_q     <= bus.in_rd;
      wb_q     <= bus.in_wb;
    end
  end

  // Result capture at the end of EXEC; the carry flag updates even when
  // the result is not written back, so compares feed a following ADC/SBC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      carry_q      <= 1'b0;
    end else if (capture) begin
      out_result_q <= bus.alu_c;
      out_carry_q  <= bus.alu_carry_out;
      out_zero_q   <= bus.alu_zero;
      carry_q      <= bus.alu_carry_out;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_RESP);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_carry  = carry_q;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_zero   = out_zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec
// Drives alu_exec through its interface, supplies a behavioural ALU beside
// it, and compares every observable output against an instruction-level
// reference model (register array + carry flag).
// ---------------------------------------------------------------------------
module tb_alu_exec;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [8:0] aluOut;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [7:0] refRegs [8];
  logic       refCarry;
  logic [7:0] refResult;

  alu_exec_if #(.RW(3)) bus ();

  alu_exec #(.NREGS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: bit 8 is carry (borrow for subtracts); CMP reports
  // 0xFF/borrow when a<b, 0x00/zero when equal, 0x01 when greater
  function automatic logic [8:0] aluFn(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic cin);
    case (op)
      OP_ADD:   return {1'b0, a} + {1'b0, b};
      OP_ADC:   return {1'b0, a} + {1'b0, b} + {8'd0, cin};
      OP_SUB:   return {1'b0, a} - {1'b0, b};
      OP_SBC:   return {1'b0, a} - {1'b0, b} - {8'd0, cin};
      OP_OR:    return {1'b0, a | b};
      OP_AND:   return {1'b0, a & b};
      OP_NOT:   return {1'b0, ~a};
      OP_XOR:   return {1'b0, a ^ b};
      OP_PASSA: return {1'b0, a};
      OP_CMP:   return (a < b) ? 9'h1FF : ((a == b) ? 9'h000 : 9'h001);
      OP_SHL:   return {a, 1'b0};
      OP_SHR:   return {a[0], 1'b0, a[7:1]};
      default:  return 9'h000;
    endcase
  endfunction

  // ALU placed beside the stage, fed by its operand registers
  always_comb begin
    aluOut            = aluFn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_carry);
    bus.alu_c         = aluOut[7:0];
    bus.alu_carry_out = aluOut[8];
    bus.alu_zero      = (aluOut[7:0] == 8'h00);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) refRegs[i] = 8'h00;
    refCarry  = 1'b0;
    refResult = 8'h00;
  endtask

  // One full instruction: offer, accept, execute, respond with holdCycles
  // of downstream back-pressure, then hand over. Model updates afterwards.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd,
                               input logic [2:0] ra, input logic [2:0] rb,
                               input logic useImm, input logic [7:0] imm,
                               input logic wb, input int holdCycles);
    logic [7:0] opA;
    logic [7:0] opB;
    logic [8:0] expRes;
    int         waitCycles;
    opA    = useImm ? imm : refRegs[ra];
    opB    = refRegs[rb];
    expRes = aluFn(op, opA, opB, refCarry);

    @(negedge clk);
    bus.in_op      = op;
    bus.in_rd      = rd;
    bus.in_ra      = ra;
    bus.in_rb      = rb;
    bus.in_use_imm = useImm;
    bus.in_imm     = imm;
    bus.in_wb      = wb;
    bus.in_valid   = 1'b1;
    waitCycles     = 0;
    while (bus.in_ready !== 1'b1 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("in_ready_offer", bus.in_ready, 1);

    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("exec_out_valid", bus.out_valid, 0);
    checkOutput("exec_in_ready", bus.in_ready, 0);
    checkOutput("exec_alu_a", bus.alu_a, opA);
    checkOutput("exec_alu_b", bus.alu_b, opB);
    checkOutput("exec_alu_op", bus.alu_op, op);
    checkOutput("exec_alu_carry", bus.alu_carry, refCarry);
    checkOutput("exec_result_unchanged", bus.out_result, refResult);

    @(negedge clk);
    checkOutput("resp_out_valid", bus.out_valid, 1);
    checkOutput("resp_in_ready", bus.in_ready, 0);
    checkOutput("resp_result", bus.out_result, expRes[7:0]);
    checkOutput("resp_carry", bus.out_carry, expRes[8]);
    checkOutput("resp_zero", bus.out_zero, (expRes[7:0] == 8'h00));

    for (int i = 0; i < holdCycles; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_PASSA;
      bus.in_wb    = 1'b1;
      bus.in_rd    = 3'(i);
      @(negedge clk);
      checkOutput("hold_out_valid", bus.out_valid, 1);
      checkOutput("hold_in_ready", bus.in_ready, 0);
      checkOutput("hold_result", bus.out_result, expRes[7:0]);
      checkOutput("hold_carry", bus.out_carry, expRes[8]);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("done_out_valid", bus.out_valid, 0);
    checkOutput("done_in_ready", bus.in_ready, 1);
    checkOutput("done_result_held", bus.out_result, expRes[7:0]);

    if (wb) refRegs[rd] = expRes[7:0];
    refCarry  = expRes[8];
    refResult = expRes[7:0];
  endtask

  task automatic readReg(input logic [2:0] r, input logic [7:0] expected, input string tag);
    applyStimulus(OP_PASSA, 3'd0, r, 3'd0, 1'b0, 8'h00, 1'b0, 0);
    checkOutput(tag, bus.out_result, expected);
  endtask

  initial begin
    logic [3:0] opList [12];
    opList = '{OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_OR, OP_AND,
               OP_NOT, OP_XOR, OP_PASSA, OP_CMP, OP_SHL, OP_SHR};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_op      = 4'd0;
    bus.in_rd      = 3'd0;
    bus.in_ra      = 3'd0;
    bus.in_rb      = 3'd0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = 8'h00;
    bus.in_wb      = 1'b0;
    bus.out_ready  = 1'b0;
    resetModel();

    $display("[TB] reset values");
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_result", bus.out_result, 8'h00);
    checkOutput("rst_out_carry", bus.out_carry, 0);
    checkOutput("rst_out_zero", bus.out_zero, 0);
    checkOutput("rst_alu_a", bus.alu_a, 8'h00);
    checkOutput("rst_alu_b", bus.alu_b, 8'h00);
    checkOutput("rst_alu_op", bus.alu_op, 4'h0);
    checkOutput("rst_alu_carry", bus.alu_carry, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    $display("[TB] directed sequence");
    applyStimulus(OP_PASSA, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 1'b1, 0);
    checkOutput("load_r1_result", bus.out_result, 8'h7F);
    checkOutput("load_r1_carry", bus.out_carry, 0);
    checkOutput("load_r1_zero", bus.out_zero, 0);
    applyStimulus(OP_PASSA, 3'd2, 3'd0, 3'd0, 1'b1, 8'h81, 1'b1, 0);
    applyStimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1'b1, 0);
    checkOutput("add_result", bus.out_result, 8'h00);
    checkOutput("add_carry", bus.out_carry, 1);
    checkOutput("add_zero", bus.out_zero, 1);
    applyStimulus(OP_ADC, 3'd4, 3'd1, 3'd1, 1'b0, 8'h00, 1'b1, 0);
    checkOutput("adc_result", bus.out_result, 8'hFF);
    checkOutput("adc_carry", bus.out_carry, 0);
    applyStimulus(OP_CMP, 3'd5, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 5);
    checkOutput("cmp_result", bus.out_result, 8'hFF);
    checkOutput("cmp_carry", bus.out_carry, 1);
    readReg(3'd1, 8'h7F, "reg_r1");
    readReg(3'd2, 8'h81, "reg_r2");
    readReg(3'd3, 8'h00, "reg_r3");
    readReg(3'd4, 8'hFF, "reg_r4");
    readReg(3'd5, 8'h00, "reg_r5_after_cmp");

    $display("[TB] reset during execute");
    @(negedge clk);
    bus.in_op      = OP_PASSA;
    bus.in_rd      = 3'd5;
    bus.in_use_imm = 1'b1;
    bus.in_imm     = 8'h55;
    bus.in_wb      = 1'b1;
    bus.in_valid   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("midrst_in_exec", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_alu_a", bus.alu_a, 8'h00);
    checkOutput("midrst_out_result", bus.out_result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    @(negedge clk);
    checkOutput("midrst_release_in_ready", bus.in_ready, 1);
    checkOutput("midrst_release_out_valid", bus.out_valid, 0);
    readReg(3'd5, 8'h00, "reg_r5_after_reset");
    readReg(3'd1, 8'h00, "reg_r1_after_reset");

    $display("[TB] randomized instructions");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(opList[$urandom_range(0, 11)], 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 2)));
    end
    for (int r = 0; r < 8; r++) begin
      readReg(3'(r), refRegs[r], "reg_final");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
